// File: rtl/xram_arbiter.sv
// xram_arbiter: round-robin arbiter sharing one XRAM port among byte-wide bus masters,
// with abort handling and a watchdog that force-completes stuck transactions.
`default_nettype none

module xram_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int GRANT_W        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_stb,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [16*NUM_MASTERS-1:0] m_addr,
  input  logic [8*NUM_MASTERS-1:0]  m_data_out,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [7:0]                m_data_in,
  output logic [15:0]               xram_addr,
  output logic [7:0]                xram_data_out,
  input  logic [7:0]                xram_data_in,
  input  logic                      xram_ack,
  output logic                      xram_stb,
  output logic                      xram_wr,
  output logic                      arb_busy,
  output logic [GRANT_W-1:0]        arb_grant,
  output logic                      arb_timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   last_q;
  logic [7:0]           cnt_q;

  logic [GRANT_W-1:0]   sel_d;
  logic                 g_stb;
  logic                 g_wr;
  logic [15:0]          g_addr;
  logic [7:0]           g_data;
  logic [NUM_MASTERS-1:0] g_onehot;
  logic                 busy;
  logic                 expire;
  logic                 complete;
  logic                 tmo;
  logic                 done;

  // Search upward from the master after the last one served, wrapping.
  always_comb begin
    int  idx;
    logic found;
    sel_d = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_stb[idx]) begin
        sel_d = GRANT_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    g_stb    = 1'b0;
    g_wr     = 1'b0;
    g_addr   = 16'h0000;
    g_data   = 8'h00;
    g_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (GRANT_W'(i) == grant_q) begin
        g_stb       = m_stb[i];
        g_wr        = m_wr[i];
        g_addr      = m_addr[16*i +: 16];
        g_data      = m_data_out[8*i +: 8];
        g_onehot[i] = 1'b1;
      end
    end
  end

  assign busy     = (state_q == BUSY);
  assign expire   = (TIMEOUT_CYCLES != 0) && (cnt_q == 8'(TIMEOUT_CYCLES));
  // A coincident XRAM ack beats the watchdog and completes normally.
  assign complete = busy && g_stb && xram_ack;
  assign tmo      = busy && g_stb && !xram_ack && expire;
  assign done     = !g_stb || xram_ack || expire;

  assign xram_stb      = busy && g_stb && (xram_ack || !expire);
  assign xram_wr       = xram_stb && g_wr;
  assign xram_addr     = xram_stb ? g_addr : 16'h0000;
  assign xram_data_out = xram_stb ? g_data : 8'h00;

  assign m_ack       = (complete || tmo) ? g_onehot : '0;
  assign m_data_in   = complete ? xram_data_in : (tmo ? 8'hFF : 8'h00);
  assign arb_timeout = tmo;
  assign arb_busy    = busy;
  assign arb_grant   = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_MASTERS - 1);
      cnt_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_stb) begin
            grant_q <= sel_d;
            cnt_q   <= 8'h00;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/xram_arbiter.md
Name: xram_arbiter

Overview:
- Shares the single XRAM port among several bus masters: CPU/xiommu path, the memory-write copy engine, and crypto accelerators.
- Each master issues single-byte stb/wr/addr transactions and waits for an ack.
- The arbiter grants one master at a time in round-robin order and forwards that master's transaction to XRAM.
- It returns XRAM's ack and read data to the granted master, and fails stuck transactions with a watchdog timeout.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
GRANT_W, 2, width of grant index; must satisfy 2^GRANT_W >= NUM_MASTERS
TIMEOUT_CYCLES, 255, BUSY cycles without xram_ack before forced completion; 0 disables the watchdog (max 255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
m_stb  input  NUM_MASTERS  per-master request strobe, held until its m_ack
m_wr  input  NUM_MASTERS  per-master write enable
m_addr  input  16*NUM_MASTERS  per-master address, master i at [16i+15:16i]
m_data_out  input  8*NUM_MASTERS  per-master write data, master i at [8i+7:8i]
m_ack  output  NUM_MASTERS  per-master completion, one-cycle pulse
m_data_in  output  8  read data broadcast to all masters, valid with m_ack
xram_addr  output  16  XRAM address
xram_data_out  output  8  XRAM write data
xram_data_in  input  8  XRAM read data
xram_ack  input  1  XRAM completion
xram_stb  output  1  XRAM strobe
xram_wr  output  1  XRAM write enable
arb_busy  output  1  high in BUSY state
arb_grant  output  GRANT_W  index of current or last granted master
arb_timeout  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous, active-low.
- Reset values (rst low), effective immediately regardless of clock:
  - state IDLE, arb_grant 0, last_grant NUM_MASTERS-1 (master 0 has first priority)
  - watchdog counter 0
  - all outputs 0: m_ack, m_data_in, xram_stb, xram_wr, xram_addr, xram_data_out, arb_busy, arb_timeout
- Reset mid-transaction: the transaction is dropped with no ack. The master must reissue it.
- States: IDLE, BUSY.
- IDLE:
  - If any m_stb is high, select the first requester searching upward (mod NUM_MASTERS) from last_grant+1.
  - Register the selection into arb_grant, clear the watchdog, go to BUSY next cycle.
  - xram_stb is 0 in IDLE, so there is a one-cycle arbitration bubble per transaction.
- BUSY, with g = arb_grant:
  - xram_stb = m_stb[g]. xram_wr, xram_addr and xram_data_out are combinational muxes of master g's signals.
  - When xram_stb=0 (IDLE or abort), xram_addr and xram_data_out drive 0.
  - xram_ack=1: m_ack[g]=1 and m_data_in=xram_data_in in the same cycle. last_grant<=g, go to IDLE.
  - m_stb[g] falls before ack (abort): xram_stb=0 that cycle, no m_ack, go to IDLE, last_grant<=g.
  - Watchdog (TIMEOUT_CYCLES>0): 8-bit counter increments each BUSY cycle without ack.
  - On the cycle the counter equals TIMEOUT_CYCLES:
    - xram_stb=0, m_ack[g]=1, m_data_in=8'hFF, arb_timeout=1
    - go to IDLE, last_grant<=g
  - xram_ack in the same cycle as expiry: the ack wins as a normal completion and arb_timeout stays 0.
- Never more than one m_ack bit high in a cycle. m_ack is 0 for non-granted masters even if xram_ack is spurious.
- m_data_in is 0 whenever no m_ack is asserted.
- Requests arriving while BUSY wait. A master holding stb continuously gets at most one transaction per round-robin turn, so masters doing long copies (e.g. mem_wr) cannot starve others.
- Throughput for a single master with a 1-cycle-ack XRAM: one byte per 2 cycles.
- arb_busy = (state==BUSY). arb_grant holds its value through IDLE.

Test Plan:
- Single master read: m_stb[1]=1, m_wr=0, m_addr[1]=16'h0040, XRAM acks next cycle with 8'hA5.
  -> xram_stb high 1 cycle after request with xram_addr=16'h0040; m_ack[1] pulses with m_data_in=8'hA5; m_ack[0], m_ack[2] stay 0.
- All three masters hold stb continuously, XRAM acks immediately.
  -> grants sequence 0,1,2,0,1,2; each m_ack is spaced 6 cycles apart per master.
- Write path: master 2 writes 8'h3C to 16'hF000.
  -> xram_wr=1, xram_data_out=8'h3C, xram_addr=16'hF000 until ack; m_ack[2] pulses.
- Watchdog with TIMEOUT_CYCLES=4, XRAM never acks.
  -> after 4 BUSY cycles: xram_stb drops, m_ack[g]=1, m_data_in=8'hFF, arb_timeout pulses, state returns to IDLE.
- Expiry collision: xram_ack coincides with watchdog expiry.
  -> normal completion with xram_data_in; arb_timeout stays 0.
- Abort and reset: master 0 drops stb mid-BUSY.
  -> no ack, IDLE next cycle, master 1 is served next.
- rst asserted low mid-BUSY between clock edges.
  -> all outputs 0 immediately; after release, master 0 has first priority.
